// File: rtl/n_bit_pipe_adder_pkg.sv
// Shared types and helpers for the pipelined N-bit adder.
// Saturation is selected by the N_BIT_PIPE_ADDER_SAT_EN macro.
package n_bit_pipe_adder_pkg;

    // Building blocks for the signed limits: MAX = {0, 1..1}, MIN = {1, 0..0}.
    localparam logic POS_LIMIT_MSB  = 1'b0;
    localparam logic POS_LIMIT_FILL = 1'b1;

    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } out_flags_t;

    function automatic int seg_width(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit params_ok(input int n, input int stages);
        return (n >= 2) && (stages >= 1) && (stages <= n)
            && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/n_bit_pipe_adder_segment.sv
// One SEG-bit slice of the pipelined adder; purely combinational.
// Shared by all builds (N_BIT_PIPE_ADDER_SAT_EN does not affect it).
module adder_segment
    import n_bit_pipe_adder_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           cmsb
);

    logic [SEG:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
        sum  = full[SEG-1:0];
        cout = full[SEG];
        // Carry into the top bit, recovered from the sum bit.
        cmsb = a[SEG-1] ^ b[SEG-1] ^ full[SEG-1];
    end

endmodule

// File: rtl/n_bit_pipe_adder.sv
// Pipelined N-bit add/subtract with carry-registered segments and valid/ready.
// Define N_BIT_PIPE_ADDER_SAT_EN to clamp overflowing results to the signed limit.
module n_bit_pipe_adder
    import n_bit_pipe_adder_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] answer,
    output logic         carry_out,
    output logic         overflow
);

    localparam int SEG = seg_width(N, STAGES);
    localparam int L   = STAGES - 1;

    if (!params_ok(N, STAGES)) begin : g_bad_params
        $error("n_bit_pipe_adder: need N >= 2 and N %% STAGES == 0");
    end

    logic en;

    // Per-segment inputs: low slices hold finished sum bits, high slices
    // still hold the skewed operands waiting for their carry.
    logic [N-1:0]   st_a     [STAGES];
    logic [N-1:0]   st_b     [STAGES];
    logic           st_c     [STAGES];
    logic           st_v     [STAGES];
    logic [SEG-1:0] seg_sum  [STAGES];
    logic           seg_cout [STAGES];
    logic           seg_cmsb [STAGES];

    logic [N-1:0] ans_d, ans_q;
    out_flags_t   flg_d, flg_q;

    assign en       = !flg_q.valid || out_ready;
    assign in_ready = en;

    assign st_a[0] = input1;
    assign st_b[0] = sub ? ~input2 : input2;
    assign st_c[0] = sub;
    assign st_v[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (st_a[k][k*SEG +: SEG]),
            .b    (st_b[k][k*SEG +: SEG]),
            .cin  (st_c[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k]),
            .cmsb (seg_cmsb[k])
        );

        if (k < L) begin : g_reg
            logic [N-1:0] a_d, a_q;
            logic [N-1:0] b_d, b_q;
            logic         c_d, c_q;
            logic         v_d, v_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                c_d = c_q;
                v_d = v_q;
                if (en) begin
                    a_d                  = st_a[k];
                    a_d[k*SEG +: SEG]    = seg_sum[k];
                    b_d                  = st_b[k];
                    c_d                  = seg_cout[k];
                    v_d                  = st_v[k];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    c_q <= c_d;
                    v_q <= v_d;
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
            assign st_c[k+1] = c_q;
            assign st_v[k+1] = v_q;
        end
    end

`ifdef N_BIT_PIPE_ADDER_SAT_EN
    localparam logic [N-1:0] S_MAX = {POS_LIMIT_MSB, {(N-1){POS_LIMIT_FILL}}};
    localparam logic [N-1:0] S_MIN = {~POS_LIMIT_MSB, {(N-1){~POS_LIMIT_FILL}}};
`endif

    always_comb begin
        ans_d = ans_q;
        flg_d = flg_q;
        if (en) begin
            ans_d               = st_a[L];
            ans_d[L*SEG +: SEG] = seg_sum[L];
            flg_d.valid         = st_v[L];
            flg_d.carry         = seg_cout[L];
            flg_d.ovf           = seg_cmsb[L] ^ seg_cout[L];
`ifdef N_BIT_PIPE_ADDER_SAT_EN
            // Top bit of st_a[L] is still operand A's sign.
            if (flg_d.ovf) begin
                ans_d = st_a[L][N-1] ? S_MIN : S_MAX;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ans_q <= '0;
            flg_q <= '0;
        end else begin
            ans_q <= ans_d;
            flg_q <= flg_d;
        end
    end

    assign out_valid = flg_q.valid;
    assign answer    = ans_q;
    assign carry_out = flg_q.carry;
    assign overflow  = flg_q.ovf;

endmodule

// File: tb/tb_n_bit_pipe_adder.sv
// Self-checking bench for n_bit_pipe_adder (8/2, 8/4 and 32/4 builds).
// Expectations follow N_BIT_PIPE_ADDER_SAT_EN when it is defined.
module tb_n_bit_pipe_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Shared stimulus for the two 8-bit instances.
    logic       in_valid8  = 1'b0;
    logic       sub8       = 1'b0;
    logic       out_ready8 = 1'b1;
    logic [7:0] in1_8      = '0;
    logic [7:0] in2_8      = '0;

    logic       a_in_ready, a_out_valid, a_carry, a_ovf;
    logic [7:0] a_answer;
    logic       c_in_ready, c_out_valid, c_carry, c_ovf;
    logic [7:0] c_answer;

    logic        b_in_valid  = 1'b0;
    logic        b_sub       = 1'b0;
    logic        b_out_ready = 1'b1;
    logic [31:0] b_in1       = '0;
    logic [31:0] b_in2       = '0;
    logic        b_in_ready, b_out_valid, b_carry, b_ovf;
    logic [31:0] b_answer;

    n_bit_pipe_adder #(.N(8), .STAGES(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(a_in_ready),
        .input1(in1_8), .input2(in2_8), .sub(sub8),
        .out_valid(a_out_valid), .out_ready(out_ready8),
        .answer(a_answer), .carry_out(a_carry), .overflow(a_ovf)
    );

    n_bit_pipe_adder #(.N(8), .STAGES(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(c_in_ready),
        .input1(in1_8), .input2(in2_8), .sub(sub8),
        .out_valid(c_out_valid), .out_ready(out_ready8),
        .answer(c_answer), .carry_out(c_carry), .overflow(c_ovf)
    );

    n_bit_pipe_adder #(.N(32), .STAGES(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .input1(b_in1), .input2(b_in2), .sub(b_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .answer(b_answer), .carry_out(b_carry), .overflow(b_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on signed integers, independent of bit tricks.
    function automatic void golden(input int n, input longint unsigned a,
                                   input longint unsigned b, input bit s,
                                   output longint unsigned ans,
                                   output bit c, output bit o);
        longint m  = longint'(1) << n;
        longint h  = longint'(1) << (n - 1);
        longint sa = (longint'(a) >= h) ? longint'(a) - m : longint'(a);
        longint sb = (longint'(b) >= h) ? longint'(b) - m : longint'(b);
        longint r  = s ? sa - sb : sa + sb;
        o = (r >= h) || (r < -h);
        if (s) begin
            c   = (a >= b);
            ans = (a - b) & longint'(m - 1);
        end else begin
            c   = ((a + b) >> n) != 0;
            ans = (a + b) & longint'(m - 1);
        end
`ifdef N_BIT_PIPE_ADDER_SAT_EN
        if (o) ans = (sa < 0) ? longint'(h) : longint'(h - 1);
`endif
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] ans;
        logic [7:0] ans_sat;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] exp_ans;
`ifdef N_BIT_PIPE_ADDER_SAT_EN
        exp_ans = v.ans_sat;
`else
        exp_ans = v.ans;
`endif
        @(negedge clk);
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        in1_8      = v.a;
        in2_8      = v.b;
        sub8       = v.s;
        check($sformatf("v%0d_in_ready", idx), 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check($sformatf("v%0d_a_early", idx), 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_a_valid", idx), 64'(a_out_valid), 64'd1);
        check($sformatf("v%0d_a_res", idx), 64'({a_answer, a_carry, a_ovf}),
              64'({exp_ans, v.c, v.o}));
        @(posedge clk); #1;
        check($sformatf("v%0d_c_early", idx), 64'(c_out_valid), 64'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_c_valid", idx), 64'(c_out_valid), 64'd1);
        check($sformatf("v%0d_c_res", idx), 64'({c_answer, c_carry, c_ovf}),
              64'({exp_ans, v.c, v.o}));
    endtask

    task automatic backpressure();
        logic [9:0] exp_q [$];
        logic [9:0] held_val;
        logic [9:0] ev;
        logic       held;
        int         sent;
        int         got;
        longint unsigned ga;
        bit gc, go;
        sent = 0;
        got  = 0;
        held = 1'b0;
        held_val = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready8 = !(cyc >= 3 && cyc <= 6);
            in_valid8  = (sent < 8);
            in1_8      = 8'(16 * sent + 3);
            in2_8      = 8'(sent + 1);
            sub8       = sent[0];
            @(negedge clk);
            if (held) begin
                check("bp_hold_valid", 64'(a_out_valid), 64'd1);
                check("bp_hold_data", 64'({a_answer, a_carry, a_ovf}),
                      64'(held_val));
            end
            held = 1'b0;
            if (a_out_valid) begin
                if (!out_ready8) begin
                    check("bp_in_ready", 64'(a_in_ready), 64'd0);
                    held     = 1'b1;
                    held_val = {a_answer, a_carry, a_ovf};
                end else if (exp_q.size() == 0) begin
                    check("bp_spurious", 64'd1, 64'd0);
                    got++;
                end else begin
                    ev = exp_q.pop_front();
                    check($sformatf("bp_beat%0d", got),
                          64'({a_answer, a_carry, a_ovf}), 64'(ev));
                    got++;
                end
            end
            if (in_valid8 && a_in_ready) begin
                golden(8, 64'(in1_8), 64'(in2_8), sub8, ga, gc, go);
                exp_q.push_back({ga[7:0], gc, go});
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        check("bp_sent", 64'(sent), 64'd8);
        check("bp_got", 64'(got), 64'd8);
    endtask

    task automatic reset_in_flight();
        int nvalid;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        out_ready8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid8 = 1'b1;
            in1_8     = 8'(8'h20 + i);
            in2_8     = 8'h01;
            sub8      = 1'b0;
            @(posedge clk); #1;
        end
        rst   = 1'b1;
        in1_8 = 8'hA0;
        in2_8 = 8'h05;
        @(posedge clk); #1;
        check("rst_valid", 64'(c_out_valid), 64'd0);
        check("rst_outs", 64'({c_answer, c_carry, c_ovf}), 64'd0);
        rst   = 1'b0;
        in1_8 = 8'h40;
        in2_8 = 8'h02;
        sub8  = 1'b1;
        check("rst_in_ready", 64'(c_in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        nvalid = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (c_out_valid) begin
                nvalid++;
                check("rst_new_lat", 64'(cyc), 64'd4);
                check("rst_new_res", 64'({c_answer, c_carry, c_ovf}),
                      64'({8'h3E, 1'b1, 1'b0}));
            end
            @(posedge clk); #1;
        end
        check("rst_beat_count", 64'(nvalid), 64'd1);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_stream();
        logic [33:0] exp_q [$];
        logic [33:0] ev;
        int sent;
        int got;
        longint unsigned ga;
        bit gc, go;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40000 && got < 10000; cyc++) begin
            b_in_valid  = (sent < 10000) && (cyc < 40 || $urandom_range(3) != 0);
            b_out_ready = (cyc < 40) || ($urandom_range(3) != 0);
            b_in1       = rand_op();
            b_in2       = rand_op();
            b_sub       = 1'($urandom_range(1));
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rs_spurious", 64'd1, 64'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check($sformatf("rs_beat%0d", got),
                          64'({b_answer, b_carry, b_ovf}), 64'(ev));
                end
                got++;
            end
            if (b_in_valid && b_in_ready) begin
                golden(32, 64'(b_in1), 64'(b_in2), b_sub, ga, gc, go);
                exp_q.push_back({ga[31:0], gc, go});
                sent++;
            end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        check("rs_got", 64'(got), 64'd10000);
    endtask

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h33, 8'h33, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h80, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[8] = '{8'h12, 8'h34, 1'b0, 8'h46, 8'h46, 1'b0, 1'b0};
        vecs[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 8'h2C, 1'b1, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_a_outs", 64'({a_out_valid, a_answer, a_carry, a_ovf}), 64'd0);
        check("reset_c_outs", 64'({c_out_valid, c_answer, c_carry, c_ovf}), 64'd0);
        check("reset_b_outs", 64'({b_out_valid, b_answer, b_carry, b_ovf}), 64'd0);
        check("reset_in_ready", 64'({a_in_ready, c_in_ready, b_in_ready}), 64'h7);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        backpressure();
        reset_in_flight();
        random_stream();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
